// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS issue stage: op classes, encodings,
// and pipeline timing constants.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADDU  = 4'd1,
    OP_SUBU  = 4'd2,
    OP_SLT   = 4'd3,
    OP_JR    = 4'd4,
    OP_ADDI  = 4'd5,
    OP_ADDIU = 4'd6,
    OP_ORI   = 4'd7,
    OP_LW    = 4'd8,
    OP_SW    = 4'd9,
    OP_BEQ   = 4'd10,
    OP_LUI   = 4'd11,
    OP_J     = 4'd12,
    OP_JAL   = 4'd13
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Tuse: cycles after D before the operand is consumed.
  localparam int unsigned TUSE_BRANCH = 0;
  localparam int unsigned TUSE_ALU    = 1;
  localparam int unsigned TUSE_STORE  = 2;

  // Tnew: cycles after E entry before the result can be forwarded.
  localparam int unsigned TNEW_LINK = 0;
  localparam int unsigned TNEW_ALU  = 1;
  localparam int unsigned TNEW_LOAD = 2;

endpackage

// File: rtl/hazard_issue_unit_if.sv
// D-stage request/stall and D/E register outputs of the issue stage.
interface hazard_issue_unit_if
  import mips_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned TW   = 2
);
  localparam int unsigned RW = $clog2(NREG);

  logic          id_valid;
  logic [31:0]   id_instr;
  logic          flush;
  logic          stall;
  logic          e_valid;
  logic [31:0]   e_instr;
  op_e           e_op;
  logic [RW-1:0] e_a1;
  logic [RW-1:0] e_a2;
  logic [RW-1:0] e_a3;
  logic [TW-1:0] e_tnew;

  modport master (
    output id_valid, id_instr, flush,
    input  stall, e_valid, e_instr, e_op, e_a1, e_a2, e_a3, e_tnew
  );

  modport slave (
    input  id_valid, id_instr, flush,
    output stall, e_valid, e_instr, e_op, e_a1, e_a2, e_a3, e_tnew
  );

endinterface

// File: rtl/instr_class.sv
// Combinational instruction classifier: op class, register indices, which
// sources are read, their Tuse, and the destination Tnew.
module instr_class
  import mips_pkg::*;
#(
  parameter int unsigned TW = 2
) (
  input  logic [31:0]      instr,
  output op_e              op,
  output logic [REG_W-1:0] a1,
  output logic [REG_W-1:0] a2,
  output logic [REG_W-1:0] a3,
  output logic             use1,
  output logic             use2,
  output logic [TW-1:0]    tuse1,
  output logic [TW-1:0]    tuse2,
  output logic [TW-1:0]    tnew,
  output logic             has_dst
);

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    op = OP_NOP;
    case (instr[31:26])
      OPC_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU: op = OP_ADDU;
          FN_SUBU: op = OP_SUBU;
          FN_SLT:  op = OP_SLT;
          FN_JR:   op = OP_JR;
          default: op = OP_NOP;
        endcase
      end
      OPC_ADDI:  op = OP_ADDI;
      OPC_ADDIU: op = OP_ADDIU;
      OPC_ORI:   op = OP_ORI;
      OPC_LW:    op = OP_LW;
      OPC_SW:    op = OP_SW;
      OPC_BEQ:   op = OP_BEQ;
      OPC_LUI:   op = OP_LUI;
      OPC_J:     op = OP_J;
      OPC_JAL:   op = OP_JAL;
      default:   op = OP_NOP;
    endcase
  end

  always_comb begin
    a1      = instr[25:21];
    a2      = instr[20:16];
    a3      = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    tuse1   = '0;
    tuse2   = '0;
    tnew    = '0;
    has_dst = 1'b0;
    case (op)
      OP_ADDU, OP_SUBU, OP_SLT: begin
        a3      = instr[15:11];
        use1    = 1'b1;
        use2    = 1'b1;
        tuse1   = TW'(TUSE_ALU);
        tuse2   = TW'(TUSE_ALU);
        tnew    = TW'(TNEW_ALU);
        has_dst = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ORI: begin
        a3      = instr[20:16];
        use1    = 1'b1;
        tuse1   = TW'(TUSE_ALU);
        tnew    = TW'(TNEW_ALU);
        has_dst = 1'b1;
      end
      OP_LUI: begin
        a3      = instr[20:16];
        tnew    = TW'(TNEW_ALU);
        has_dst = 1'b1;
      end
      OP_LW: begin
        a3      = instr[20:16];
        use1    = 1'b1;
        tuse1   = TW'(TUSE_ALU);
        tnew    = TW'(TNEW_LOAD);
        has_dst = 1'b1;
      end
      OP_SW: begin
        use1  = 1'b1;
        use2  = 1'b1;
        tuse1 = TW'(TUSE_ALU);
        tuse2 = TW'(TUSE_STORE);
      end
      OP_BEQ: begin
        use1  = 1'b1;
        use2  = 1'b1;
        tuse1 = TW'(TUSE_BRANCH);
        tuse2 = TW'(TUSE_BRANCH);
      end
      OP_JR: begin
        use1  = 1'b1;
        tuse1 = TW'(TUSE_BRANCH);
      end
      OP_JAL: begin
        a3      = REG_RA;
        tnew    = TW'(TNEW_LINK);
        has_dst = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_issue_unit.sv
// Decode/issue stage: scoreboard of in-flight destinations, RAW stall
// detection, D/E pipeline register and saturating stall counter.
module hazard_issue_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TW    = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_issue_unit_if.slave bus,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned RW = $clog2(NREG);

  op_e              d_op;
  logic [REG_W-1:0] d_a1_raw, d_a2_raw, d_a3_raw;
  logic             d_use1, d_use2, d_has_dst;
  logic [TW-1:0]    d_tuse1, d_tuse2, d_tnew;
  logic [RW-1:0]    d_a1, d_a2, d_a3;

  instr_class #(.TW(TW)) u_instr_class (
    .instr   (bus.id_instr),
    .op      (d_op),
    .a1      (d_a1_raw),
    .a2      (d_a2_raw),
    .a3      (d_a3_raw),
    .use1    (d_use1),
    .use2    (d_use2),
    .tuse1   (d_tuse1),
    .tuse2   (d_tuse2),
    .tnew    (d_tnew),
    .has_dst (d_has_dst)
  );

  assign d_a1 = RW'(d_a1_raw);
  assign d_a2 = RW'(d_a2_raw);
  assign d_a3 = RW'(d_a3_raw);

  logic [DEPTH-1:0]         sb_valid;
  logic [DEPTH-1:0][RW-1:0] sb_dst;
  logic [DEPTH-1:0][TW-1:0] sb_tnew;

  logic hazard;
  logic issue;

  function automatic logic [TW-1:0] age(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sb_valid[k]) begin
        if (d_use1 && (d_a1 != '0) && (sb_dst[k] == d_a1) && (sb_tnew[k] > d_tuse1))
          hazard = 1'b1;
        if (d_use2 && (d_a2 != '0) && (sb_dst[k] == d_a2) && (sb_tnew[k] > d_tuse2))
          hazard = 1'b1;
      end
    end
  end

  assign bus.stall = bus.id_valid & hazard & ~bus.flush;
  assign issue     = bus.id_valid & ~hazard & ~bus.flush;

  // Entry 0 shadows the D/E register; older entries age by one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      sb_dst   <= '0;
      sb_tnew  <= '0;
    end else begin
      sb_valid[0] <= issue & d_has_dst & (d_a3 != '0);
      sb_dst[0]   <= issue ? d_a3 : '0;
      sb_tnew[0]  <= (issue && d_has_dst) ? d_tnew : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dst[k]   <= sb_dst[k-1];
        sb_tnew[k]  <= age(sb_tnew[k-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.e_valid <= 1'b0;
      bus.e_instr <= '0;
      bus.e_op    <= OP_NOP;
      bus.e_a1    <= '0;
      bus.e_a2    <= '0;
      bus.e_a3    <= '0;
      bus.e_tnew  <= '0;
    end else if (issue) begin
      bus.e_valid <= 1'b1;
      bus.e_instr <= bus.id_instr;
      bus.e_op    <= d_op;
      bus.e_a1    <= d_a1;
      bus.e_a2    <= d_a2;
      bus.e_a3    <= d_a3;
      bus.e_tnew  <= d_tnew;
    end else begin
      bus.e_valid <= 1'b0;
      bus.e_instr <= '0;
      bus.e_op    <= OP_NOP;
      bus.e_a1    <= '0;
      bus.e_a2    <= '0;
      bus.e_a3    <= '0;
      bus.e_tnew  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (bus.stall && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_issue_unit.sv
// Directed bench for hazard_issue_unit: instruction pairs with hand-computed
// stall lengths, E-stage contents, flush priority and asynchronous reset.
module tb_hazard_issue_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] stall_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_cnt = 0;

  hazard_issue_unit_if #(.NREG(32), .TW(2)) bus ();

  hazard_issue_unit #(
    .DEPTH (3),
    .NREG  (32),
    .TW    (2),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LW_8     = {6'b100011, 5'd0, 5'd8, 16'd0};
  localparam logic [31:0] LW_9     = {6'b100011, 5'd0, 5'd9, 16'd0};
  localparam logic [31:0] ADDU_988 = {6'b000000, 5'd8, 5'd8, 5'd9, 5'd0, 6'b100001};
  localparam logic [31:0] ADDU_812 = {6'b000000, 5'd1, 5'd2, 5'd8, 5'd0, 6'b100001};
  localparam logic [31:0] ADDU_012 = {6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001};
  localparam logic [31:0] ADDU_300 = {6'b000000, 5'd0, 5'd0, 5'd3, 5'd0, 6'b100001};
  localparam logic [31:0] BEQ_80   = {6'b000100, 5'd8, 5'd0, 16'd0};
  localparam logic [31:0] JAL_4    = {6'b000011, 26'd4};
  localparam logic [31:0] JR_31    = {6'b000000, 5'd31, 15'd0, 6'b001000};
  localparam logic [31:0] SW_8_9   = {6'b101011, 5'd9, 5'd8, 16'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      bus.id_valid = 1'b0;
      bus.id_instr = '0;
      bus.flush    = 1'b0;
    end
  endtask

  // Issue `first`, then hold `second` in D until it issues.
  task automatic run_pair(input string tag, input logic [31:0] first, input logic [31:0] second,
                          input int unsigned exp_stalls, input logic [4:0] a3_first,
                          input logic [1:0] tnew_first, input logic [4:0] a3_second);
    int unsigned n;
    @(negedge clk);
    bus.id_valid = 1'b1;
    bus.id_instr = first;
    bus.flush    = 1'b0;
    #1 check({tag, ".stall_first"}, 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.id_instr = second;
    #1;
    check({tag, ".e_a3_first"}, 32'(bus.e_a3), 32'(a3_first));
    check({tag, ".e_tnew_first"}, 32'(bus.e_tnew), 32'(tnew_first));
    n = 0;
    while (bus.stall && n < 8) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, ".stalls"}, n, exp_stalls);
    exp_cnt += exp_stalls;
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.id_instr = '0;
    #1;
    check({tag, ".e_valid"}, 32'(bus.e_valid), 32'd1);
    check({tag, ".e_instr"}, bus.e_instr, second);
    check({tag, ".e_a3"}, 32'(bus.e_a3), 32'(a3_second));
    check({tag, ".stall_count"}, 32'(stall_count), exp_cnt);
    idle(3);
  endtask

  initial begin
    bus.id_valid = 1'b0;
    bus.id_instr = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.e_valid", 32'(bus.e_valid), 32'd0);
    check("rst.e_op", 32'(bus.e_op), 32'(OP_NOP));
    check("rst.e_instr", bus.e_instr, 32'd0);
    check("rst.stall_count", 32'(stall_count), 32'd0);
    check("rst.stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;
    idle(1);

    run_pair("lw_addu",  LW_8,     ADDU_988, 1, 5'd8,  2'd2, 5'd9);
    run_pair("lw_beq",   LW_8,     BEQ_80,   2, 5'd8,  2'd2, 5'd0);
    run_pair("addu_beq", ADDU_812, BEQ_80,   1, 5'd8,  2'd1, 5'd0);
    run_pair("jal_jr",   JAL_4,    JR_31,    0, 5'd31, 2'd0, 5'd0);
    run_pair("r0_dst",   ADDU_012, ADDU_300, 0, 5'd0,  2'd1, 5'd3);
    run_pair("lw_sw_rt", LW_8,     SW_8_9,   0, 5'd8,  2'd2, 5'd0);
    run_pair("lw_sw_rs", LW_9,     SW_8_9,   1, 5'd9,  2'd2, 5'd0);

    // Flush beats a pending hazard.
    @(negedge clk);
    bus.id_valid = 1'b1;
    bus.id_instr = LW_8;
    @(negedge clk);
    bus.id_instr = ADDU_988;
    bus.flush    = 1'b1;
    #1 check("flush.stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("flush.e_valid", 32'(bus.e_valid), 32'd0);
    check("flush.stall_count", 32'(stall_count), exp_cnt);
    idle(3);

    // Reset asserted between clock edges while a stall is active.
    @(negedge clk);
    bus.id_valid = 1'b1;
    bus.id_instr = LW_8;
    @(negedge clk);
    bus.id_instr = ADDU_988;
    #1 check("mid.stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.e_valid", 32'(bus.e_valid), 32'd0);
    check("mid.stall_count", 32'(stall_count), 32'd0);
    check("mid.stall", 32'(bus.stall), 32'd0);
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 0;
    idle(1);
    run_pair("post_rst", LW_8, ADDU_988, 1, 5'd8, 2'd2, 5'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_issue_unit.md
# hazard_issue_unit

Decode-and-issue stage for the five-stage MIPS core. Classifies the 32-bit instruction in D, computes source/destination register indices and timing classes (Tuse/Tnew), and tracks in-flight destination registers in a parametrised scoreboard. Stalls D on read-after-write hazards that cannot be satisfied in time. Owns the D/E pipeline register, inserting bubbles on stall or flush.

## Interface
- DEPTH, 3: tracked post-decode stages (E, M, W, ...); ≥ 2, must exceed the maximum Tnew.
- NREG, 32: architectural registers; index width is RW = clog2(NREG).
- TW, 2: width of Tuse/Tnew fields.
- CNT_W, 16: stall-counter width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  D holds a real instruction
- id_instr  in  32  instruction in D
- flush  in  1  kill the instruction in D this cycle
- stall  out  1  combinational; hold PC and F/D register
- e_valid  out  1  E-stage instruction is real
- e_instr  out  32  registered instruction
- e_op  out  enum  registered op class (op_e)
- e_a1, e_a2, e_a3  out  RW each  registered rs, rt, destination
- e_tnew  out  TW  registered Tnew at E entry
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Recognised ops:
  - R-type (op 000000): addu 100001, subu 100011, slt 101010, jr 001000.
  - I/J-type by op: addi 001000, addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
  - Anything else is OP_NOP: no sources, no destination.
- Register fields: A1 = instr[25:21], A2 = instr[20:16].
- Destination A3:
  - addu, subu, slt: [15:11]
  - ori, lw, lui, addi, addiu: [20:16]
  - jal: 31
  - all others: 0
- Tuse per source (only sources actually read count):
  - beq rs/rt and jr rs: 0
  - ALU rs/rt and lw/sw rs: 1
  - sw rt: 2
  - j, jal, lui: no sources
- Tnew at E entry:
  - ALU ops (addu, subu, slt, ori, lui, addi, addiu): 1
  - lw: 2
  - jal: 0
  - others: no destination
- Scoreboard: DEPTH entries {valid, dst, tnew}. Entry 0 mirrors the D/E register. Each clock:
  - entry k+1 ← entry k with tnew' = max(tnew−1, 0);
  - entry DEPTH−1 is discarded;
  - entry 0 ← the newly issued instruction, or a bubble.
- Hazard, per source s with Tuse u: some entry is valid with dst ≠ 0, dst == s, and tnew > u. stall = id_valid & any hazard & ~flush.
- D/E register update:
  - flush, stall, or ~id_valid: load a bubble (e_valid = 0, all other fields 0).
  - otherwise: load the decoded fields.
- stall_count increments on each stall cycle and saturates at all-ones.
- Register $0 never creates a hazard or a scoreboard destination (dst forced valid = 0).

## Timing
- stall is combinational from id_instr, id_valid, flush and scoreboard state, in the same cycle.
- Issue latency: one cycle from D to the e_* outputs.
- The downstream pipeline never stalls; the scoreboard shifts every cycle.
- Reset (async assert, sync deassert by the system):
  - all scoreboard entries invalid;
  - all e_* outputs 0, e_op = OP_NOP;
  - stall_count = 0;
  - stall = 0 until a valid instruction arrives.
- Simultaneous flush and hazard: flush wins. Bubble issued, stall = 0, counter unchanged.
- Reset mid-stall: the stall is dropped immediately and in-flight entries are lost.
- Repeated stall cycles: the same D instruction is re-evaluated each cycle against the aging scoreboard.

## Structure
- Package mips_pkg holds:
  - op_e enum;
  - opcode and funct localparams;
  - Tuse/Tnew constants;
  - REG_RA = 31.
- Sub-module instr_class: purely combinational; instr → op, A1/A2/A3, use flags, Tuse pair, Tnew.
- The top level holds the scoreboard shift array, hazard compare, D/E register and counter.

## Test plan
- lw $8,0($0) then addu $9,$8,$8 back-to-back → stall = 1 for exactly 1 cycle; addu reaches E with e_a3 = 9; stall_count = 1.
- lw $8 then beq $8,$0 → 2 stall cycles; addu $8 then beq $8,$0 → 1 stall cycle.
- jal then jr $31 → no stall; jal in E shows e_a3 = 31, e_tnew = 0.
- addu $0,$1,$2 then addu $3,$0,$0 → no stall.
- lw $8 then sw $8,0($9) → no stall (sw rt Tuse = 2). lw $9 then sw $8,0($9) → 1 stall cycle.
- lw $8 with addu $9,$8,$8 held in D plus flush asserted → no stall, bubble in E. Then rst_n low mid-stall → e_valid = 0 and stall_count = 0 asynchronously.
